sigmoid_inverse_sar: RTL and testbench
======================================

// Module: sigmoid_inverse_sar
// PURPOSE
//  Inverts the piecewise-linear sigmoid. Input is a Q0.16 probability y. Output is the signed Q3.4 x.
//  x is the largest value with f(x) <= y, where f is the exact PWL curve the forward sigmoid block computes.
//  Uses an 8-step successive-approximation search over x and one combinational forward evaluator.
//  Sits on the return path, downstream of o_y from the forward block and of any external probability source.
// PARAMETERS
//  XW    8    width of x (signed Q3.4, range -8.0 .. +7.9375); SAR step count equals XW
//  YW    16   width of y (unsigned Q0.16)
// PORTS
//  clk          input   1    clock
//  rst_n        input   1    synchronous reset, active-low
//  i_in_valid   input   1    request strobe; sampled only when o_busy=0
//  i_y          input   YW   target probability, Q0.16
//  o_busy       output  1    1 from the accepting edge until the FSM returns to IDLE
//  o_x          output  XW   result, signed Q3.4, two's complement
//  o_out_valid  output  1    one-cycle pulse; o_x and o_clip are valid while it is high
//  o_clip       output  2    [0]=y below f(-128), [1]=y at or above f(+127)
//  number       output  51   transistor count of all instantiated cells
// BEHAVIOUR
//  Reset: one clk edge with rst_n=0 gives:
//   - state=IDLE, o_busy=0, o_out_valid=0, o_x=0, o_clip=0
//   - internal trial/result/target registers are cleared
//   - any search in progress is aborted and produces no output pulse
//  Forward model f(x), shared with the forward block:
//   - segment = |x|[6:4] (|-128| saturates to segment 7)
//   - g = a[seg]*|x| + b[seg]
//   - f(x) = x>=0 ? g : 0x10000-g, truncated to 16 bits
//   - f is monotonic non-decreasing; f(0)=0x8000 exactly
//  Search runs in offset binary: u = x + 128, so u=0 means x=-128.
//  FSM states IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE:
//    - i_in_valid=1 at edge E: latch i_y, result u=0, k=7, o_busy=1, go to SEARCH
//    - otherwise hold
//   SEARCH, one bit per edge (edges E+1 .. E+8, k = 7 down to 0):
//    - trial = u | (1<<k)
//    - if f(trial-128) <= y_latched, then u = trial; k decrements
//    - after k=0, go to DONE
//   DONE (edge E+9):
//    - o_x = u-128
//    - o_clip[0] = (u==0 && f(-128) > y); o_clip[1] = (u==255)
//    - o_out_valid=1 for exactly the cycle after edge E+9
//    - next edge: IDLE, o_busy=0, o_out_valid=0
//  Timing:
//   - latency: accepting edge to o_out_valid is 9 edges
//   - throughput: one result per 10 cycles
//  Ordering and holds:
//   - i_in_valid while o_busy=1 is ignored; no queueing, no error flag
//   - o_x and o_clip hold their last value after o_out_valid falls, until the next DONE
//   - reset has priority over every other event on the same edge
//  Arithmetic:
//   - a*|x| is an 8x8 unsigned product, zero-extended to 17 bits before adding b
//   - the compare is unsigned 16-bit
//   - tie f(trial)==y keeps the bit, so the result is the largest x on flat runs
//  Clip bits are mutually exclusive.
// STRUCTURE
//  Shared package sigmoid_pkg:
//   - PWL tables A_TAB[8] (8-bit) and B_TAB[8] (16-bit)
//   - XW/YW defaults
//   - FSM state encoding: IDLE=2'b00, SEARCH=2'b01, DONE=2'b10
//  One sub-module: sigmoid_pwl_eval.
//   - combinational: |x|, segment select, multiply-add, sign fold
//   - also reused for the f(-128) clip check by the top
//  Top owns: FSM, 3-bit step counter, u/y registers, output registers.
//  number = sum of sub-module and register counts.
// TESTING
//  1. i_y=0x8000 -> o_x=0x00, o_clip=00, o_out_valid exactly 9 edges after accept
//  2. i_y=0x0000 -> o_x=0x80 (-8.0), o_clip=01
//  3. i_y=0xFFFF -> o_x=0x7F (+7.9375), o_clip=10
//  4. Sweep all 256 x: feed i_y=f(x) -> f(o_x)==f(x) and o_x>=x; feed i_y=f(x)-1 (x>-128) -> o_x<x
//  5. Pulse i_in_valid on every cycle while busy -> only the first request is answered; next accept in the cycle after DONE
//  6. rst_n=0 on edge E+4 mid-search -> no o_out_valid pulse; all outputs 0; new request after reset gives correct result

Source files
------------

// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared PWL sigmoid tables, widths and FSM encoding
//
// Shared by the forward sigmoid block and the inverse SAR search.
// Contents:
//   XW_DEF / YW_DEF   default x (signed Q3.4) and y (unsigned Q0.16) widths
//   state_t           FSM encoding for the inverse search
//   A_TAB / B_TAB     per-segment slope and intercept of g(|x|) = a*|x| + b
//   TR_PER_FLOP       transistor count of one register bit
//   PWL_EVAL_TR       transistor count of the PWL evaluator
package sigmoid_pkg;

  localparam int XW_DEF = 8;
  localparam int YW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // Segment s covers |x| in [16s, 16s+15]; |x|=128 folds into segment 7.
  // Each intercept is chosen so g is continuous at the segment boundaries,
  // which together with non-negative slopes keeps f monotonic.
  // B_TAB[0] = 0x8000 pins f(0) to exactly one half.
  localparam logic [7:0] A_TAB [8] = '{
    8'd255, 8'd220, 8'd160, 8'd100, 8'd56, 8'd28, 8'd14, 8'd6
  };

  localparam logic [15:0] B_TAB [8] = '{
    16'h8000, 16'h8230, 16'h89B0, 16'h94F0,
    16'h9FF0, 16'hA8B0, 16'hADF0, 16'hB170
  };

  localparam logic [50:0] TR_PER_FLOP = 51'd24;
  localparam logic [50:0] PWL_EVAL_TR = 51'd7416;

endpackage

// File: rtl/sigmoid_pwl_eval.sv
// rtl/sigmoid_pwl_eval.sv - combinational forward PWL sigmoid evaluator f(x)
//
// Purpose: computes f(x) for a signed Q3.4 x, bit-exact with the forward
// sigmoid block.
// Ports:
//   i_x     in   XW  signed Q3.4 argument, two's complement
//   o_f     out  YW  f(x), unsigned Q0.16
//   number  out  51  transistor count of this evaluator
module sigmoid_pwl_eval
  import sigmoid_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic [XW-1:0] i_x,
  output logic [YW-1:0] o_f,
  output logic [50:0]   number
);

  logic [XW-1:0] mag;
  logic [2:0]    seg;
  logic [15:0]   prod;
  logic [15:0]   g;

  always_comb begin
    // |x| as an unsigned 8-bit value; |-128| = 0x80 stays representable.
    mag  = i_x[XW-1] ? (~i_x + 8'd1) : i_x;
    // 0x80 has bits [6:4] clear, so it must be forced into the top segment.
    seg  = mag[XW-1] ? 3'd7 : mag[6:4];
    prod = 16'(A_TAB[seg]) * 16'(mag);
    // The result is truncated to 16 bits in both branches, so the sum and the
    // 0x10000 - g fold can both be carried out modulo 2^16 without the carry.
    g    = prod + B_TAB[seg];
    o_f  = i_x[XW-1] ? (16'd0 - g) : g;
  end

  assign number = PWL_EVAL_TR;

endmodule

// File: rtl/sigmoid_inverse_sar.sv
// rtl/sigmoid_inverse_sar.sv - inverse PWL sigmoid by 8-step successive approximation
//
// Purpose: given a Q0.16 probability y, returns the largest signed Q3.4 x
// with f(x) <= y, where f is the forward PWL sigmoid.
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   synchronous reset, active-low
//   i_in_valid   in   1   request strobe, only looked at while idle
//   i_y          in   YW  target probability, Q0.16
//   o_busy       out  1   high from the accepting edge until back in IDLE
//   o_x          out  XW  result, signed Q3.4
//   o_out_valid  out  1   one-cycle result strobe
//   o_clip       out  2   [0] y below f(-128), [1] y at or above f(+127)
//   number       out  51  transistor count of all instantiated cells
module sigmoid_inverse_sar
  import sigmoid_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic [YW-1:0] i_y,
  output logic          o_busy,
  output logic [XW-1:0] o_x,
  output logic          o_out_valid,
  output logic [1:0]    o_clip,
  output logic [50:0]   number
);

  // state(2) + k(3) + u(XW) + y(YW) + x(XW) + clip(2) + out_valid(1)
  localparam logic [50:0] REG_BITS = 51'(2 + 3 + XW + YW + XW + 2 + 1);

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [XW-1:0] u_q, u_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] x_q, x_d;
  logic [1:0]    clip_q, clip_d;
  logic          out_valid_q, out_valid_d;

  logic [XW-1:0] step;
  logic [XW-1:0] trial;
  logic [XW-1:0] eval_u;
  logic [XW-1:0] eval_x;
  logic [YW-1:0] f_val;
  logic [50:0]   eval_number;

  // The search runs on offset-binary u = x + 128; flipping the MSB converts
  // between offset binary and two's complement.
  assign eval_x = {~eval_u[XW-1], eval_u[XW-2:0]};

  sigmoid_pwl_eval #(
    .XW (XW),
    .YW (YW)
  ) u_eval (
    .i_x    (eval_x),
    .o_f    (f_val),
    .number (eval_number)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    u_d         = u_q;
    y_d         = y_q;
    x_d         = x_q;
    clip_d      = clip_q;
    out_valid_d = 1'b0;

    step        = '0;
    step[k_q]   = 1'b1;
    trial       = u_q | step;

    // One evaluator serves both phases: it scores the trial point while
    // searching, and in DONE it sees the final u, which is -128 exactly when
    // the below-range clip can apply.
    eval_u      = (state_q == ST_DONE) ? u_q : trial;

    case (state_q)
      ST_IDLE: begin
        if (i_in_valid) begin
          y_d     = i_y;
          u_d     = '0;
          k_d     = 3'(XW - 1);
          state_d = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        // Ties keep the bit, so flat runs of f resolve to their largest x.
        if (f_val <= y_q) begin
          u_d = trial;
        end
        k_d = k_q - 3'd1;
        if (k_q == 3'd0) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        x_d         = {~u_q[XW-1], u_q[XW-2:0]};
        clip_d[0]   = (u_q == '0) && (f_val > y_q);
        clip_d[1]   = &u_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      u_q         <= '0;
      y_q         <= '0;
      x_q         <= '0;
      clip_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      u_q         <= u_d;
      y_q         <= y_d;
      x_q         <= x_d;
      clip_q      <= clip_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_x         = x_q;
  assign o_clip      = clip_q;
  assign o_out_valid = out_valid_q;
  assign number      = eval_number + REG_BITS * TR_PER_FLOP;

endmodule

// File: tb/tb_sigmoid_inverse_sar.sv
// tb/tb_sigmoid_inverse_sar.sv - self-checking bench for sigmoid_inverse_sar
module tb_sigmoid_inverse_sar;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic [15:0] i_y;
  logic        o_busy;
  logic [7:0]  o_x;
  logic        o_out_valid;
  logic [1:0]  o_clip;
  logic [50:0] number;

  int checks = 0;
  int errors = 0;

  // Reference curve: forward PWL sigmoid, independent copy of the tables.
  int a_t [8] = '{255, 220, 160, 100, 56, 28, 14, 6};
  int b_t [8] = '{32768, 33328, 35248, 38128, 40944, 43184, 44528, 45424};

  sigmoid_inverse_sar dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .i_y         (i_y),
    .o_busy      (o_busy),
    .o_x         (o_x),
    .o_out_valid (o_out_valid),
    .o_clip      (o_clip),
    .number      (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int f_model(input int x);
    int m, s, g;
    m = (x < 0) ? -x : x;
    s = (m >= 128) ? 7 : m / 16;
    g = a_t[s] * m + b_t[s];
    if (x >= 0) return g & 16'hFFFF;
    return (65536 - g) & 16'hFFFF;
  endfunction

  // Exhaustive inverse: largest x with f(x) <= y, else -128 with low clip.
  task automatic inv_model(input int y, output int x, output logic [1:0] clip);
    bit found;
    found = 1'b0;
    x = -128;
    for (int xi = -128; xi <= 127; xi++) begin
      if (f_model(xi) <= y) begin
        x = xi;
        found = 1'b1;
      end
    end
    clip[0] = !found;
    clip[1] = (x == 127);
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 of the
  // result cycle (or after a 20-edge bound, reported via lat).
  task automatic run_one(input logic [15:0] y, output logic [7:0] rx,
                         output logic [1:0] rc, output int lat);
    i_y = y;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    lat = 0;
    while (o_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rx = o_x;
    rc = o_clip;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_y = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++;
    if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
    checks++;
    if (o_x !== 8'h00) begin errors++; $display("FAIL reset_x got=%h exp=00", o_x); end
    checks++;
    if (o_clip !== 2'b00) begin errors++; $display("FAIL reset_clip got=%b exp=00", o_clip); end
    checks++;
    if ($isunknown(number) || number == '0) begin errors++; $display("FAIL number got=%0d exp=nonzero", number); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_midpoint();
    logic [7:0] rx; logic [1:0] rc; int lat;
    i_y = 16'h8000;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_after_accept got=%b exp=1", o_busy); end
    lat = 0;
    while (o_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rx = o_x; rc = o_clip;
    checks++;
    if (lat != 9) begin errors++; $display("FAIL mid_latency got=%0d exp=9", lat); end
    checks++;
    if (rx !== 8'h00) begin errors++; $display("FAIL mid_x got=%h exp=00", rx); end
    checks++;
    if (rc !== 2'b00) begin errors++; $display("FAIL mid_clip got=%b exp=00", rc); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_at_valid got=%b exp=0", o_busy); end
    @(posedge clk); #1;
    checks++;
    if (o_out_valid !== 1'b0) begin errors++; $display("FAIL mid_pulse_width got=%b exp=0", o_out_valid); end
    checks++;
    if (o_x !== 8'h00 || o_clip !== 2'b00) begin errors++; $display("FAIL mid_hold got=%h/%b exp=00/00", o_x, o_clip); end
  endtask

  task automatic test_extremes();
    logic [7:0] rx; logic [1:0] rc; int lat;
    run_one(16'h0000, rx, rc, lat);
    checks++;
    if (rx !== 8'h80 || rc !== 2'b01) begin errors++; $display("FAIL y0000 got=%h/%b exp=80/01", rx, rc); end
    run_one(16'hFFFF, rx, rc, lat);
    checks++;
    if (rx !== 8'h7F || rc !== 2'b10) begin errors++; $display("FAIL yFFFF got=%h/%b exp=7f/10", rx, rc); end
    @(posedge clk); #1;
    checks++;
    if (o_x !== 8'h7F || o_clip !== 2'b10) begin errors++; $display("FAIL hold_after_valid got=%h/%b exp=7f/10", o_x, o_clip); end
  endtask

  task automatic test_sweep();
    logic [7:0] rx; logic [1:0] rc; int lat, sx, fy;
    for (int x = -128; x <= 127; x++) begin
      fy = f_model(x);
      run_one(16'(fy), rx, rc, lat);
      sx = $signed(rx);
      checks++;
      if (lat != 9 || f_model(sx) != fy || sx < x) begin
        errors++;
        $display("FAIL sweep_hit x=%0d got x=%0d f=%h lat=%0d exp f=%h x>=%0d lat=9", x, sx, f_model(sx), lat, fy, x);
      end
      if (x > -128) begin
        run_one(16'(fy - 1), rx, rc, lat);
        sx = $signed(rx);
        checks++;
        if (sx >= x) begin errors++; $display("FAIL sweep_below x=%0d got x=%0d exp x<%0d", x, sx, x); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] rx; logic [1:0] rc, ec; int lat, ex, y;
    for (int n = 0; n < 150; n++) begin
      y = (n % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(19000, 47000));
      inv_model(y, ex, ec);
      run_one(16'(y), rx, rc, lat);
      checks++;
      if (rx !== 8'(ex) || rc !== ec || rc == 2'b11) begin
        errors++;
        $display("FAIL random y=%h got=%h/%b exp=%h/%b", y, rx, rc, 8'(ex), ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx; logic [1:0] rc, ec1, ec2; int ex1, ex2, y1, y2, pulses, lat;
    bit busy_ok;
    y1 = $urandom_range(19000, 47000);
    y2 = $urandom_range(19000, 47000);
    inv_model(y1, ex1, ec1);
    inv_model(y2, ex2, ec2);
    i_y = 16'(y1);
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    busy_ok = 1'b1;
    rx = '0; rc = '0;
    for (int c = 1; c <= 9; c++) begin
      i_y = 16'($urandom);
      i_in_valid = 1'b1;
      @(posedge clk); #1;
      if (o_out_valid === 1'b1) begin pulses++; rx = o_x; rc = o_clip; end
      if (c < 9 && o_busy !== 1'b1) busy_ok = 1'b0;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL b2b_busy got=0 exp=1 during search"); end
    checks++;
    if (rx !== 8'(ex1) || rc !== ec1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=%h/%b", rx, rc, 8'(ex1), ec1); end
    // Request held high into the result cycle is taken on the very next edge.
    i_y = 16'(y2);
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_next_accept got busy=%b valid=%b exp busy=1 valid=0", o_busy, o_out_valid);
    end
    lat = 0;
    while (o_out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 9 || o_x !== 8'(ex2) || o_clip !== ec2) begin
      errors++; $display("FAIL b2b_second got=%h/%b lat=%0d exp=%h/%b lat=9", o_x, o_clip, lat, 8'(ex2), ec2);
    end
  endtask

  task automatic test_reset_mid_search();
    logic [7:0] rx; logic [1:0] rc, ec; int lat, ex, y;
    bit seen;
    run_one(16'hFFFF, rx, rc, lat);
    i_y = 16'($urandom);
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_x !== 8'h00 || o_clip !== 2'b00) begin
      errors++; $display("FAIL midreset_outputs got busy=%b valid=%b x=%h clip=%b exp 0/0/00/00", o_busy, o_out_valid, o_x, o_clip);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (o_out_valid !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_pulse got=1 exp=0"); end
    y = $urandom_range(19000, 47000);
    inv_model(y, ex, ec);
    run_one(16'(y), rx, rc, lat);
    checks++;
    if (lat != 9 || rx !== 8'(ex) || rc !== ec) begin
      errors++; $display("FAIL midreset_after got=%h/%b lat=%0d exp=%h/%b lat=9", rx, rc, lat, 8'(ex), ec);
    end
  endtask

  initial begin
    test_reset();
    test_midpoint();
    test_extremes();
    test_sweep();
    test_random();
    test_back_to_back();
    test_reset_mid_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
